// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
package booth_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} digit_t;

   // Multiplier is widened by at least one bit so unsigned operands stay positive,
   // then rounded up to an even width so every iteration retires a full bit pair.
   function automatic int calc_ax(input int a_w);
      return 2 * ((a_w + 2) / 2);
   endfunction

   function automatic int calc_iter(input int a_w);
      return calc_ax(a_w) / 2;
   endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps {b1, b0, q} to a digit and selects the addend from M.
module booth_r4_enc
   import booth_pkg::*;
#(
   parameter int PW = 11
) (
   input  logic [2:0]    bits,
   input  logic [PW-1:0] m,
   output logic [PW-1:0] addend
);

   digit_t digit;

   always_comb begin
      digit = ZERO;
      unique case (bits)
         3'b001, 3'b010: digit = P1;
         3'b011:         digit = P2;
         3'b100:         digit = M2;
         3'b101, 3'b110: digit = M1;
         default:        digit = ZERO;
      endcase
   end

   always_comb begin
      addend = '0;
      case (digit)
         P1:      addend = m;
         P2:      addend = m << 1;
         M1:      addend = -m;
         M2:      addend = -(m << 1);
         default: addend = '0;
      endcase
   end

endmodule

// File: rtl/booth_mul_r4.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per operation, valid/ready on both sides.
module booth_mul_r4
   import booth_pkg::*;
#(
   parameter int A_W   = 8,
   parameter int B_W   = 8,
   parameter int OUT_W = A_W + B_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             in_signed_i,
   input  logic [A_W-1:0]   in_A_i,
   input  logic [B_W-1:0]   in_B_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OUT_W-1:0] mult_out_o
);

   localparam int AX   = calc_ax(A_W);
   localparam int ITER = calc_iter(A_W);
   localparam int PW   = B_W + 3;
   localparam int CW   = $clog2(ITER + 1);

   if (OUT_W != A_W + B_W) begin : g_out_w_chk
      $error("booth_mul_r4: OUT_W must equal A_W+B_W");
   end
   if (A_W < 2 || B_W < 2) begin : g_in_w_chk
      $error("booth_mul_r4: A_W and B_W must be >= 2");
   end

   state_t             state, state_nxt;
   logic [CW-1:0]      cntr;
   logic [PW-1:0]      acc, m, addend, sum;
   logic [AX-1:0]      mplr;
   logic               q;
   logic               accept;
   logic [PW+AX-1:0]   shifted;

   assign in_ready_o  = !rst && (state == IDLE || (state == DONE && out_ready_i));
   assign accept      = in_valid_i && in_ready_o;
   assign out_valid_o = (state == DONE);

   booth_r4_enc #(.PW(PW)) u_enc (
      .bits   ({mplr[1:0], q}),
      .m      (m),
      .addend (addend)
   );

   // Arithmetic shift of {acc+digit, mplr} by one bit pair.
   assign sum     = acc + addend;
   assign shifted = {{2{sum[PW-1]}}, sum, mplr[AX-1:2]};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = BUSY;
         BUSY:    if (cntr == CW'(1)) state_nxt = DONE;
         DONE:    if (out_ready_i) state_nxt = accept ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cntr       <= '0;
         acc        <= '0;
         m          <= '0;
         mplr       <= '0;
         q          <= 1'b0;
         mult_out_o <= '0;
      end else if (accept) begin
         cntr <= CW'(ITER);
         acc  <= '0;
         q    <= 1'b0;
         m    <= {{(PW-B_W){in_signed_i & in_B_i[B_W-1]}}, in_B_i};
         mplr <= {{(AX-A_W){in_signed_i & in_A_i[A_W-1]}}, in_A_i};
      end else if (state == BUSY) begin
         cntr <= cntr - CW'(1);
         acc  <= shifted[PW+AX-1:AX];
         mplr <= shifted[AX-1:0];
         q    <= mplr[1];
         // Product register only moves on the final iteration, so it is stable in DONE.
         if (cntr == CW'(1)) mult_out_o <= shifted[OUT_W-1:0];
      end
   end

endmodule

// File: tb/tb_booth_mul_r4.sv
// Randomized and directed checks of booth_mul_r4 against an integer-arithmetic product model.
module tb_booth_mul_r4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        v8, s8, or8, ir8, ov8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   logic        v7, s7, or7, ir7, ov7;
   logic [6:0]  a7;
   logic [4:0]  b7;
   logic [11:0] p7;

   int checks   = 0;
   int failures = 0;

   booth_mul_r4 #(.A_W(8), .B_W(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid_i(v8), .in_ready_o(ir8), .in_signed_i(s8),
      .in_A_i(a8), .in_B_i(b8),
      .out_valid_o(ov8), .out_ready_i(or8), .mult_out_o(p8)
   );

   booth_mul_r4 #(.A_W(7), .B_W(5)) dut7 (
      .clk(clk), .rst(rst),
      .in_valid_i(v7), .in_ready_o(ir7), .in_signed_i(s7),
      .in_A_i(a7), .in_B_i(b7),
      .out_valid_o(ov7), .out_ready_i(or7), .mult_out_o(p7)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Interpret operands as integers, multiply, keep the low aw+bw bits.
   function automatic logic [63:0] ref_mul(input bit s, input logic [63:0] a, input logic [63:0] b,
                                           input int aw, input int bw);
      longint x, y, p;
      x = longint'(a);
      y = longint'(b);
      if (s && a[aw-1]) x = x - (longint'(1) << aw);
      if (s && b[bw-1]) y = y - (longint'(1) << bw);
      p = x * y;
      return 64'(p & ((longint'(1) << (aw + bw)) - 1));
   endfunction

   task automatic wait_valid8(input string tag);
      int n;
      n = 0;
      while (!ov8 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'd5);
   endtask

   task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b, input string tag);
      logic [15:0] exp;
      exp = 16'(ref_mul(s, 64'(a), 64'(b), 8, 8));
      @(negedge clk);
      or8 = 1'b0; s8 = s; a8 = a; b8 = b; v8 = 1'b1;
      #1 chk({tag, "_rdy"}, 64'(ir8), 64'd1);
      @(negedge clk);
      v8 = 1'b0;
      wait_valid8(tag);
      chk({tag, "_prod"}, 64'(p8), 64'(exp));
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
      chk({tag, "_drain"}, 64'(ov8), 64'd0);
   endtask

   logic [63:0] expq[$];
   int  n_acc, n_out;
   bit  drv_done, sw_stop;

   initial begin
      logic [15:0] held, exp2;
      bit seen;

      rst = 1'b1;
      v8 = 0; s8 = 0; or8 = 0; a8 = 0; b8 = 0;
      v7 = 0; s7 = 0; or7 = 0; a7 = 0; b7 = 0;
      repeat (3) @(negedge clk);
      chk("rst_ir8", 64'(ir8), 64'd0);
      chk("rst_ov8", 64'(ov8), 64'd0);
      chk("rst_p8",  64'(p8),  64'd0);
      chk("rst_ir7", 64'(ir7), 64'd0);
      rst = 1'b0;
      #1 chk("post_rst_ir8", 64'(ir8), 64'd1);
      @(negedge clk);
      chk("post_rst_ov8", 64'(ov8), 64'd0);
      chk("post_rst_p8",  64'(p8),  64'd0);

      run8(1'b1, 8'h80, 8'h80, "mn_mn");
      run8(1'b0, 8'hFF, 8'hFF, "u_ff");
      run8(1'b1, 8'hFF, 8'hFF, "s_ff");
      run8(1'b1, 8'h7F, 8'h80, "mx_mn");
      run8(1'b0, 8'h00, 8'hAB, "u_zero");
      for (int i = 0; i < 20; i++)
         run8(bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), "rnd");

      // Backpressure in DONE, then back-to-back accept on release.
      @(negedge clk);
      s8 = 1'b1; a8 = 8'h80; b8 = 8'h80; v8 = 1'b1; or8 = 1'b0;
      @(negedge clk);
      v8 = 1'b0;
      wait_valid8("hold");
      chk("hold_prod", 64'(p8), 64'h4000);
      held = p8;
      for (int i = 0; i < 10; i++) begin
         v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
         #1 chk("hold_ir", 64'(ir8), 64'd0);
         @(negedge clk);
         chk("hold_ov", 64'(ov8), 64'd1);
         chk("hold_p",  64'(p8),  64'(held));
      end
      s8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1; or8 = 1'b1;
      exp2 = 16'(ref_mul(1'b0, 64'h00FF, 64'h00FF, 8, 8));
      #1 chk("b2b_ir", 64'(ir8), 64'd1);
      @(negedge clk);
      v8 = 1'b0; or8 = 1'b0;
      chk("b2b_ov_low", 64'(ov8), 64'd0);
      wait_valid8("b2b");
      chk("b2b_prod", 64'(p8), 64'(exp2));
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;

      // Reset during the second BUSY cycle discards the operation.
      @(negedge clk);
      s8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3; v8 = 1'b1;
      @(negedge clk);
      v8 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ov", 64'(ov8), 64'd0);
      chk("mid_rst_ir", 64'(ir8), 64'd0);
      chk("mid_rst_p",  64'(p8),  64'd0);
      rst = 1'b0;
      #1 chk("mid_rst_ir1", 64'(ir8), 64'd1);
      seen = 1'b0;
      or8 = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (ov8) seen = 1'b1;
      end
      or8 = 1'b0;
      chk("mid_rst_abort", 64'(seen), 64'd0);

      // Exhaustive 7x5 sweep, both modes, random output backpressure.
      n_acc = 0; n_out = 0; drv_done = 1'b0; sw_stop = 1'b0;
      fork
         begin
            for (int s = 0; s < 2; s++)
               for (int a = 0; a < 128; a++)
                  for (int b = 0; b < 32; b++)
                     if (!sw_stop) begin
                        int g;
                        @(negedge clk);
                        s7 = s[0]; a7 = a[6:0]; b7 = b[4:0]; v7 = 1'b1;
                        #1;
                        g = 0;
                        while (!ir7 && g < 40) begin
                           @(negedge clk);
                           #1;
                           g++;
                        end
                        if (ir7) begin
                           expq.push_back(ref_mul(s[0], 64'(a), 64'(b), 7, 5));
                           n_acc++;
                        end else begin
                           chk("sweep_accept_timeout", 64'(ir7), 64'd1);
                           sw_stop = 1'b1;
                        end
                     end
            @(negedge clk);
            v7 = 1'b0;
            drv_done = 1'b1;
         end
         begin
            int cyc;
            cyc = 0;
            while (!(drv_done && expq.size() == 0) && cyc < 80000 && !sw_stop) begin
               @(negedge clk);
               cyc++;
               or7 = ($urandom_range(0, 3) != 0);
               if (ov7 && or7) begin
                  n_out++;
                  if (expq.size() == 0) chk("sweep_spurious", 64'd1, 64'd0);
                  else chk("sweep_prod", 64'(p7), expq.pop_front());
               end
            end
            or7 = 1'b0;
         end
      join
      chk("sweep_count", 64'(n_out), 64'(n_acc));
      chk("sweep_left",  64'(expq.size()), 64'd0);
      chk("sweep_total", 64'(n_acc), 64'd8192);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
